// File: rtl/forwarding_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : forwarding_hazard_unit_if
// Brief   : ID-stage inputs and forwarding/stall outputs shared between the
//           pipeline front end and the forwarding/hazard unit.
// Revision: 1.0  initial release
// ============================================================================
interface forwarding_hazard_unit_if #(
    parameter int STALL_CNT_WIDTH = 16
);
    logic [31:0]                if_id_instr;
    logic                       id_reg_write;
    logic                       id_mem_read;
    logic                       id_reg_dst;
    logic                       flush;
    logic [1:0]                 Forward_A;
    logic [1:0]                 Forward_B;
    logic                       pc_write_en;
    logic                       if_id_write_en;
    logic                       id_ex_bubble;
    logic [STALL_CNT_WIDTH-1:0] stall_count;

    // Pipeline side: presents the ID instruction, consumes selects and stalls.
    modport master (
        output if_id_instr, id_reg_write, id_mem_read, id_reg_dst, flush,
        input  Forward_A, Forward_B, pc_write_en, if_id_write_en,
               id_ex_bubble, stall_count
    );

    modport slave (
        input  if_id_instr, id_reg_write, id_mem_read, id_reg_dst, flush,
        output Forward_A, Forward_B, pc_write_en, if_id_write_en,
               id_ex_bubble, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : forwarding_hazard_unit
// Brief   : Shadow ID/EX, EX/MEM, MEM/WB control pipeline producing EX operand
//           forwarding selects and load-use stall/bubble controls.
// Revision: 1.0  initial release
// ============================================================================
module forwarding_hazard_unit #(
    parameter int STALL_CNT_WIDTH = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    forwarding_hazard_unit_if.slave bus
);

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

    logic [4:0] w_id_rs;
    logic [4:0] w_id_rt;
    logic [4:0] w_id_dest;
    logic       w_hazard;
    logic       w_stall;
    logic       w_bubble;

    logic [4:0] ex_rs_q,        ex_rs_d;
    logic [4:0] ex_rt_q,        ex_rt_d;
    logic [4:0] ex_dest_q,      ex_dest_d;
    logic       ex_reg_write_q, ex_reg_write_d;
    logic       ex_mem_read_q,  ex_mem_read_d;
    logic [4:0] mem_dest_q,     mem_dest_d;
    logic       mem_reg_write_q, mem_reg_write_d;
    logic [4:0] wb_dest_q,      wb_dest_d;
    logic       wb_reg_write_q, wb_reg_write_d;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // EX/MEM is checked first so the most recent producer wins; $0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_dest,
        input logic       mem_we,
        input logic [4:0] wb_dest,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (mem_we && (mem_dest != 5'd0) && (mem_dest == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_we && (wb_dest != 5'd0) && (wb_dest == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        w_id_rs   = bus.if_id_instr[25:21];
        w_id_rt   = bus.if_id_instr[20:16];
        w_id_dest = bus.id_reg_dst ? bus.if_id_instr[15:11] : bus.if_id_instr[20:16];

        // rt is compared even for I-type instructions; the occasional false stall is accepted.
        w_hazard  = ex_mem_read_q && (ex_dest_q != 5'd0) &&
                    ((ex_dest_q == w_id_rs) || (ex_dest_q == w_id_rt));
        w_stall   = w_hazard && !bus.flush;
        w_bubble  = w_stall || bus.flush;
    end

    always_comb begin
        ex_rs_d         = w_id_rs;
        ex_rt_d         = w_id_rt;
        ex_dest_d       = w_id_dest;
        ex_reg_write_d  = bus.id_reg_write;
        ex_mem_read_d   = bus.id_mem_read;
        if (w_bubble) begin
            ex_rs_d        = 5'd0;
            ex_rt_d        = 5'd0;
            ex_dest_d      = 5'd0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end

        mem_dest_d      = ex_dest_q;
        mem_reg_write_d = ex_reg_write_q;
        wb_dest_d       = mem_dest_q;
        wb_reg_write_d  = mem_reg_write_q;

        stall_count_d = stall_count_q;
        if (w_stall && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs_q         <= 5'd0;
            ex_rt_q         <= 5'd0;
            ex_dest_q       <= 5'd0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_dest_q      <= 5'd0;
            mem_reg_write_q <= 1'b0;
            wb_dest_q       <= 5'd0;
            wb_reg_write_q  <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_dest_q       <= ex_dest_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_dest_q      <= mem_dest_d;
            mem_reg_write_q <= mem_reg_write_d;
            wb_dest_q       <= wb_dest_d;
            wb_reg_write_q  <= wb_reg_write_d;
            stall_count_q   <= stall_count_d;
        end
    end

    assign bus.Forward_A      = fwd_sel(ex_rs_q, mem_dest_q, mem_reg_write_q,
                                        wb_dest_q, wb_reg_write_q);
    assign bus.Forward_B      = fwd_sel(ex_rt_q, mem_dest_q, mem_reg_write_q,
                                        wb_dest_q, wb_reg_write_q);
    assign bus.pc_write_en    = !w_stall;
    assign bus.if_id_write_en = !w_stall;
    assign bus.id_ex_bubble   = w_bubble;
    assign bus.stall_count    = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_forwarding_hazard_unit
// Brief   : Scoreboard bench for forwarding_hazard_unit, 16-bit and 2-bit
//           stall counter instances driven in lockstep.
// Revision: 1.0  initial release
// ============================================================================
module tb_forwarding_hazard_unit;

    logic clk;
    logic reset;

    forwarding_hazard_unit_if #(.STALL_CNT_WIDTH(16)) bus16 ();
    forwarding_hazard_unit_if #(.STALL_CNT_WIDTH(2))  bus2 ();

    forwarding_hazard_unit #(.STALL_CNT_WIDTH(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    forwarding_hazard_unit #(.STALL_CNT_WIDTH(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic [15:0] c16;
        logic [1:0]  c2;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: one record per shadow stage.
    logic [4:0] m_ex_rs, m_ex_rt, m_ex_dest, m_mem_dest, m_wb_dest;
    logic       m_ex_rw, m_ex_mr, m_mem_rw, m_wb_rw;
    int         m_stalls;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input int rd, input int rs, input int rt);
        logic [4:0] a, b, d;
        a = 5'(rs); b = 5'(rt); d = 5'(rd);
        return {6'd0, a, b, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] lw(input int rt, input int base);
        logic [4:0] a, b;
        a = 5'(base); b = 5'(rt);
        return {6'h23, a, b, 16'd0};
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (m_mem_rw && m_mem_dest != 0 && m_mem_dest == src) return 2'b10;
        if (m_wb_rw && m_wb_dest != 0 && m_wb_dest == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_ex_rs = 0; m_ex_rt = 0; m_ex_dest = 0; m_ex_rw = 0; m_ex_mr = 0;
        m_mem_dest = 0; m_mem_rw = 0; m_wb_dest = 0; m_wb_rw = 0;
        m_stalls = 0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic rw, input logic mr,
                         input logic rdst, input logic fl);
        bus16.if_id_instr = instr; bus2.if_id_instr = instr;
        bus16.id_reg_write = rw;   bus2.id_reg_write = rw;
        bus16.id_mem_read = mr;    bus2.id_mem_read = mr;
        bus16.id_reg_dst = rdst;   bus2.id_reg_dst = rdst;
        bus16.flush = fl;          bus2.flush = fl;
    endtask

    // One ID cycle: called just after a rising edge, returns just after the next.
    task automatic step(input logic [31:0] instr, input logic rw, input logic mr,
                        input logic rdst, input logic fl, input logic rst_in);
        exp_t       e, got;
        logic [4:0] rs, rt, dest;
        logic       hz, stall, bub;
        drive(instr, rw, mr, rdst, fl);
        reset = rst_in;
        rs   = instr[25:21];
        rt   = instr[20:16];
        dest = rdst ? instr[15:11] : instr[20:16];
        hz    = m_ex_mr && (m_ex_dest != 0) && (m_ex_dest == rs || m_ex_dest == rt);
        stall = hz && !fl;
        bub   = stall || fl;
        e.fa  = m_fwd(m_ex_rs);
        e.fb  = m_fwd(m_ex_rt);
        e.pcw = !stall;
        e.ifw = !stall;
        e.bub = bub;
        e.c16 = 16'((m_stalls > 65535) ? 65535 : m_stalls);
        e.c2  = 2'((m_stalls > 3) ? 3 : m_stalls);
        sb.push_back(e);

        @(negedge clk);
        last.fa  = bus16.Forward_A;
        last.fb  = bus16.Forward_B;
        last.pcw = bus16.pc_write_en;
        last.ifw = bus16.if_id_write_en;
        last.bub = bus16.id_ex_bubble;
        last.c16 = bus16.stall_count;
        last.c2  = bus2.stall_count;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check_eq("fwd_a",    32'(last.fa),  32'(got.fa));
            check_eq("fwd_b",    32'(last.fb),  32'(got.fb));
            check_eq("pc_we",    32'(last.pcw), 32'(got.pcw));
            check_eq("ifid_we",  32'(last.ifw), 32'(got.ifw));
            check_eq("bubble",   32'(last.bub), 32'(got.bub));
            check_eq("cnt16",    32'(last.c16), 32'(got.c16));
            check_eq("cnt2",     32'(last.c2),  32'(got.c2));
            check_eq("fwd_a_w2", 32'(bus2.Forward_A),    32'(got.fa));
            check_eq("bub_w2",   32'(bus2.id_ex_bubble), 32'(got.bub));
        end

        if (rst_in) begin
            model_clear();
        end else begin
            m_wb_dest = m_mem_dest; m_wb_rw = m_mem_rw;
            m_mem_dest = m_ex_dest; m_mem_rw = m_ex_rw;
            if (bub) begin
                m_ex_rs = 0; m_ex_rt = 0; m_ex_dest = 0; m_ex_rw = 0; m_ex_mr = 0;
            end else begin
                m_ex_rs = rs; m_ex_rt = rt; m_ex_dest = dest; m_ex_rw = rw; m_ex_mr = mr;
            end
            if (stall) m_stalls++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input int rd, input int rs, input int rt, input logic fl);
        step(r_type(rd, rs, rt), 1'b1, 1'b0, 1'b1, fl, 1'b0);
    endtask

    task automatic load(input int rt, input int base);
        step(lw(rt, base), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_clear();
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        do_reset(2);

        // Reset state
        nop();
        check_eq("rst_fa",  32'(last.fa), 32'd0);
        check_eq("rst_pcw", 32'(last.pcw), 32'd1);
        check_eq("rst_bub", 32'(last.bub), 32'd0);
        check_eq("rst_cnt", 32'(last.c16), 32'd0);

        // ALU chain
        alu(3, 1, 2, 1'b0);
        alu(4, 3, 5, 1'b0);
        alu(6, 3, 4, 1'b0);
        check_eq("chain_sub_fa", 32'(last.fa), 32'h2);
        nop();
        check_eq("chain_or_fa", 32'(last.fa), 32'h1);
        check_eq("chain_or_fb", 32'(last.fb), 32'h2);
        nop(); nop(); nop();

        // Load-use
        load(8, 1);
        alu(9, 8, 2, 1'b0);
        check_eq("lu_pcw", 32'(last.pcw), 32'd0);
        check_eq("lu_ifw", 32'(last.ifw), 32'd0);
        check_eq("lu_bub", 32'(last.bub), 32'd1);
        alu(9, 8, 2, 1'b0);
        check_eq("lu_cnt", 32'(last.c16), 32'd1);
        check_eq("lu_nostall", 32'(last.pcw), 32'd1);
        nop();
        check_eq("lu_fa", 32'(last.fa), 32'h1);
        nop(); nop();

        // Flush beats stall
        load(8, 1);
        alu(9, 8, 2, 1'b1);
        check_eq("fl_pcw", 32'(last.pcw), 32'd1);
        check_eq("fl_bub", 32'(last.bub), 32'd1);
        nop();
        check_eq("fl_cnt", 32'(last.c16), 32'd1);
        nop(); nop();

        // $0 never forwards or stalls
        alu(0, 1, 2, 1'b0);
        alu(10, 0, 0, 1'b0);
        nop();
        check_eq("r0_fa", 32'(last.fa), 32'd0);
        check_eq("r0_fb", 32'(last.fb), 32'd0);
        load(0, 1);
        alu(11, 0, 0, 1'b0);
        check_eq("r0_nostall", 32'(last.pcw), 32'd1);
        nop(); nop();

        // Two producers of $7: EX/MEM wins
        alu(7, 1, 2, 1'b0);
        alu(7, 7, 3, 1'b0);
        alu(11, 1, 7, 1'b0);
        check_eq("prio_mid_fa", 32'(last.fa), 32'h2);
        nop();
        check_eq("prio_fb", 32'(last.fb), 32'h2);
        nop(); nop();

        // Reset asserted in the stall cycle
        load(8, 1);
        step(r_type(9, 8, 2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("rst_mid_pcw", 32'(last.pcw), 32'd0);
        alu(9, 8, 2, 1'b0);
        check_eq("rst_mid_pcw2", 32'(last.pcw), 32'd1);
        check_eq("rst_mid_cnt", 32'(last.c16), 32'd0);
        nop(); nop();

        // Saturation of the 2-bit counter
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            load(8, 1);
            alu(9, 8, 2, 1'b0);
            alu(9, 8, 2, 1'b0);
            check_eq("sat_cnt2", 32'(last.c2), 32'(sat_exp[i]));
            check_eq("sat_cnt16", 32'(last.c16), 32'(i + 1));
        end
        nop(); nop();

        // Random traffic on a small register set
        for (int i = 0; i < 60; i++) begin
            logic fl;
            fl = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0)
                step(lw($urandom_range(0, 7), $urandom_range(0, 7)), 1'b1, 1'b1, 1'b0, fl, 1'b0);
            else
                step(r_type($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                     1'($urandom), 1'b0, 1'($urandom), fl, 1'b0);
        end

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
